and_result_stage: RTL

Registered output stage placed directly downstream of `and_gate_8bit`. It captures each valid AND result (`cout`) into a 2-entry buffer, computes flags (zero, all-ones, population count) at capture, and presents results to the next stage over a valid/ready handshake. This decouples the combinational AND datapath from a consumer that may stall.

---
 rtl/and_result_stage_if.sv | 36 +++
 rtl/and_result_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/and_result_stage_if.sv
//------------------------------------------------------------------------------
// Module      : and_result_stage_if
// Description : Producer/consumer handshake bundle for and_result_stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface and_result_stage_if #(
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;
  logic [PW-1:0]    out_pop;
  logic [7:0]       acc_count;

  // Environment side: drives the producer inputs and the consumer ready.
  modport master (
    output in_valid, cout, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones, out_pop, acc_count
  );

  modport slave (
    input  in_valid, cout, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones, out_pop, acc_count
  );
endinterface

`default_nettype wire

// File: rtl/and_result_stage.sv
//------------------------------------------------------------------------------
// Module      : and_result_stage
// Description : Two-entry registered output buffer for an AND result, with
//               zero/all-ones/popcount flags computed at capture time.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module and_result_stage #(
  parameter int WIDTH = 8
) (
  input wire logic            clk,
  input wire logic            rst,
  and_result_stage_if.slave   bus
);
  localparam int PW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Head entry drives out_* directly; tail holds the second entry when FULL.
  logic [WIDTH-1:0] r_head_data, w_head_data_nxt;
  logic             r_head_zero, w_head_zero_nxt;
  logic             r_head_ones, w_head_ones_nxt;
  logic [PW-1:0]    r_head_pop,  w_head_pop_nxt;
  logic [WIDTH-1:0] r_tail_data, w_tail_data_nxt;
  logic             r_tail_zero, w_tail_zero_nxt;
  logic             r_tail_ones, w_tail_ones_nxt;
  logic [PW-1:0]    r_tail_pop,  w_tail_pop_nxt;
  logic [7:0]       r_acc_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_zero;
  logic             w_ones;
  logic [PW-1:0]    w_popcnt;

  assign w_in_ready  = !rst && (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + PW'(bus.cout[i]);
    end
  end

  assign w_zero = (bus.cout == '0);
  assign w_ones = (bus.cout == '1);

  always_comb begin
    w_state_nxt     = r_state;
    w_head_data_nxt = r_head_data;
    w_head_zero_nxt = r_head_zero;
    w_head_ones_nxt = r_head_ones;
    w_head_pop_nxt  = r_head_pop;
    w_tail_data_nxt = r_tail_data;
    w_tail_zero_nxt = r_tail_zero;
    w_tail_ones_nxt = r_tail_ones;
    w_tail_pop_nxt  = r_tail_pop;

    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt     = ONE;
          w_head_data_nxt = bus.cout;
          w_head_zero_nxt = w_zero;
          w_head_ones_nxt = w_ones;
          w_head_pop_nxt  = w_popcnt;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_head_data_nxt = bus.cout;
          w_head_zero_nxt = w_zero;
          w_head_ones_nxt = w_ones;
          w_head_pop_nxt  = w_popcnt;
        end else if (w_push) begin
          w_state_nxt     = FULL;
          w_tail_data_nxt = bus.cout;
          w_tail_zero_nxt = w_zero;
          w_tail_ones_nxt = w_ones;
          w_tail_pop_nxt  = w_popcnt;
        end else if (w_pop) begin
          // Clear the head so out_* read as zero while empty.
          w_state_nxt     = EMPTY;
          w_head_data_nxt = '0;
          w_head_zero_nxt = 1'b0;
          w_head_ones_nxt = 1'b0;
          w_head_pop_nxt  = '0;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_state_nxt     = ONE;
          w_head_data_nxt = r_tail_data;
          w_head_zero_nxt = r_tail_zero;
          w_head_ones_nxt = r_tail_ones;
          w_head_pop_nxt  = r_tail_pop;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_head_data <= '0;
      r_head_zero <= 1'b0;
      r_head_ones <= 1'b0;
      r_head_pop  <= '0;
      r_tail_data <= '0;
      r_tail_zero <= 1'b0;
      r_tail_ones <= 1'b0;
      r_tail_pop  <= '0;
      r_acc_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_zero <= w_head_zero_nxt;
      r_head_ones <= w_head_ones_nxt;
      r_head_pop  <= w_head_pop_nxt;
      r_tail_data <= w_tail_data_nxt;
      r_tail_zero <= w_tail_zero_nxt;
      r_tail_ones <= w_tail_ones_nxt;
      r_tail_pop  <= w_tail_pop_nxt;
      if (w_push) begin
        r_acc_count <= r_acc_count + 8'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_head_data;
  assign bus.out_zero  = r_head_zero;
  assign bus.out_ones  = r_head_ones;
  assign bus.out_pop   = r_head_pop;
  assign bus.acc_count = r_acc_count;
endmodule

`default_nettype wire
